// File: rtl/rfphoenix_pma_checker_if.sv
// Bundles the request, region, PMT memory and response signals of the PMA checker.
// The slave modport is the checker's own view. The master modport is the view of
// whatever surrounds the checker: the front-end, the region lookup and PMT memory.
interface rfphoenix_pma_checker_if;
  logic        req_valid;
  logic        req_ready;
  logic [47:0] req_adr;
  logic [2:0]  req_acc;
  logic [3:0]  region_num;
  logic [19:0] region_at;
  logic [47:0] region_pmt;
  logic        region_err;
  logic        inval;
  logic        mem_req;
  logic [47:0] mem_adr;
  logic        mem_ack;
  logic [31:0] mem_dat;
  logic        mem_err;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_ok;
  logic [3:0]  rsp_cause;
  logic        rsp_cacheable;

  modport slave (
    input  req_valid, req_adr, req_acc, region_num, region_at, region_pmt, region_err,
    input  inval, mem_ack, mem_dat, mem_err, rsp_ready,
    output req_ready, mem_req, mem_adr, rsp_valid, rsp_ok, rsp_cause, rsp_cacheable
  );

  modport master (
    output req_valid, req_adr, req_acc, region_num, region_at, region_pmt, region_err,
    output inval, mem_ack, mem_dat, mem_err, rsp_ready,
    input  req_ready, mem_req, mem_adr, rsp_valid, rsp_ok, rsp_cause, rsp_cacheable
  );
endinterface

// File: rtl/rfphoenix_pma_checker.sv
// PMA checker. It checks a physical-address request against the attributes of its
// matched region. When the region has a PMT, the checker also fetches and checks
// the per-page PMT entry, and it caches one entry.
module rfphoenix_pma_checker #(
  parameter int unsigned PAGE_SHIFT = 16,
  parameter int unsigned TMO        = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  rfphoenix_pma_checker_if.slave bus
);

  localparam int unsigned TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_FETCH,
    S_RESP
  } state_e;

  typedef enum logic [3:0] {
    C_OK     = 4'd0,
    C_NOREG  = 4'd1,
    C_RDENY  = 4'd2,
    C_BUSERR = 4'd3,
    C_PINVAL = 4'd4,
    C_PDENY  = 4'd5
  } cause_e;

  state_e      state_q;

  // Request and region descriptor, captured at acceptance.
  logic [13:0] page_q;
  logic [2:0]  acc_q;
  logic [3:0]  num_q;
  logic [3:0]  at_q;
  logic [47:0] pmt_q;
  logic        err_q;

  // Single-entry PMT cache, tagged by {region, page}.
  logic        c_valid_q;
  logic [17:0] c_tag_q;
  logic [3:0]  c_entry_q;

  // Fetch bookkeeping.
  logic [TW-1:0] tmo_q;
  logic          inval_seen_q;
  logic          mem_req_q;
  logic [47:0]   mem_adr_q;

  // Registered response.
  logic        rsp_valid_q;
  logic        rsp_ok_q;
  logic [3:0]  rsp_cause_q;
  logic        rsp_cacheable_q;

  // Combinational decode of the CHECK and FETCH outcomes.
  logic        hit;
  logic        chk_fetch;
  cause_e      chk_cause;
  cause_e      fetch_cause;
  logic [47:0] fetch_adr;

  // Entry rules, first match wins: invalid entry, then missing permission.
  function automatic cause_e eval_entry(input logic [3:0] entry, input logic [2:0] acc);
    cause_e c;
    if (!entry[3]) begin
      c = C_PINVAL;
    end else if ((acc & ~entry[2:0]) != 3'b000) begin
      c = C_PDENY;
    end else begin
      c = C_OK;
    end
    return c;
  endfunction

  // CHECK rules in priority order. A miss on a PMT region requests a fetch.
  always_comb begin
    hit       = c_valid_q && (c_tag_q == {num_q, page_q});
    chk_fetch = 1'b0;
    chk_cause = C_OK;
    fetch_adr = pmt_q + {32'd0, page_q, 2'b00};
    if (err_q) begin
      chk_cause = C_NOREG;
    end else if ((acc_q & ~at_q[2:0]) != 3'b000) begin
      chk_cause = C_RDENY;
    end else if (pmt_q == '0) begin
      chk_cause = C_OK;
    end else if (hit) begin
      chk_cause = eval_entry(c_entry_q, acc_q);
    end else begin
      chk_fetch = 1'b1;
    end
  end

  // Outcome of a returning PMT read.
  always_comb begin
    fetch_cause = C_OK;
    if (bus.mem_err) begin
      fetch_cause = C_BUSERR;
    end else begin
      fetch_cause = eval_entry(bus.mem_dat[3:0], acc_q);
    end
  end

  // Main FSM: request capture, check, PMT fetch with timeout, response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      page_q          <= '0;
      acc_q           <= '0;
      num_q           <= '0;
      at_q            <= '0;
      pmt_q           <= '0;
      err_q           <= 1'b0;
      c_valid_q       <= 1'b0;
      c_tag_q         <= '0;
      c_entry_q       <= '0;
      tmo_q           <= '0;
      inval_seen_q    <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_adr_q       <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_ok_q        <= 1'b0;
      rsp_cause_q     <= '0;
      rsp_cacheable_q <= 1'b0;
    end else begin
      // The cache fill in FETCH is gated by inval, so an invalidate always wins.
      if (bus.inval) begin
        c_valid_q <= 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            page_q  <= bus.req_adr[PAGE_SHIFT+13:PAGE_SHIFT];
            acc_q   <= bus.req_acc;
            num_q   <= bus.region_num;
            at_q    <= bus.region_at[3:0];
            pmt_q   <= bus.region_pmt;
            err_q   <= bus.region_err;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (chk_fetch) begin
            state_q      <= S_FETCH;
            mem_req_q    <= 1'b1;
            mem_adr_q    <= fetch_adr;
            tmo_q        <= '0;
            inval_seen_q <= bus.inval;
          end else begin
            state_q         <= S_RESP;
            rsp_valid_q     <= 1'b1;
            rsp_ok_q        <= (chk_cause == C_OK);
            rsp_cause_q     <= chk_cause;
            rsp_cacheable_q <= (chk_cause == C_OK) & at_q[3];
          end
        end
        S_FETCH: begin
          if (bus.inval) begin
            inval_seen_q <= 1'b1;
          end
          if (bus.mem_ack) begin
            mem_req_q       <= 1'b0;
            state_q         <= S_RESP;
            rsp_valid_q     <= 1'b1;
            rsp_ok_q        <= (fetch_cause == C_OK);
            rsp_cause_q     <= fetch_cause;
            rsp_cacheable_q <= (fetch_cause == C_OK) & at_q[3];
            // An invalidate seen during the fetch still lets this response use
            // the entry, but the entry is not kept in the cache.
            if (!bus.mem_err && !inval_seen_q && !bus.inval) begin
              c_valid_q <= 1'b1;
              c_tag_q   <= {num_q, page_q};
              c_entry_q <= bus.mem_dat[3:0];
            end
          end else if (tmo_q == TW'(TMO - 1)) begin
            mem_req_q       <= 1'b0;
            state_q         <= S_RESP;
            rsp_valid_q     <= 1'b1;
            rsp_ok_q        <= 1'b0;
            rsp_cause_q     <= C_BUSERR;
            rsp_cacheable_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_adr       = mem_adr_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_ok        = rsp_ok_q;
  assign bus.rsp_cause     = rsp_cause_q;
  assign bus.rsp_cacheable = rsp_cacheable_q;

  // Address bits outside the page index, upper attributes and upper PMT word bits
  // carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.req_adr[47:PAGE_SHIFT+14], bus.req_adr[PAGE_SHIFT-1:0],
                         bus.region_at[19:4], bus.mem_dat[31:4]};

endmodule

// File: tb/tb_rfphoenix_pma_checker.sv
// Bench for rfphoenix_pma_checker. A stimulus process issues requests and pushes
// the expected response and PMT read plan. A monitor checks responses, and a memory
// process answers PMT reads.
module tb_rfphoenix_pma_checker;
  localparam int unsigned TMO = 255;

  logic clk;
  logic rst_n;
  logic inval_stim;
  logic inval_mem;
  int   cyc;
  int   n_assert;
  int   n_fail;
  int   hold;
  bit   cur_active;

  typedef struct {
    logic       ok;
    logic [3:0] cause;
    logic       cac;
    bit         chk_lat;
    int         acc_cyc;
  } exp_t;

  typedef struct {
    logic [47:0] adr;
    int unsigned dly;
    logic [31:0] dat;
    logic        err;
    bit          noack;
    bit          abort;
    bit          inval_mid;
  } plan_t;

  exp_t  exp_q[$];
  plan_t mem_q[$];

  // Reference cache: one entry tagged by {region, page}.
  bit          m_valid;
  logic [17:0] m_tag;
  logic [3:0]  m_entry;

  logic [19:0] at_t  [4];
  logic [47:0] pmt_t [4];
  logic [13:0] page_t[4];

  rfphoenix_pma_checker_if bus();

  rfphoenix_pma_checker #(.PAGE_SHIFT(16), .TMO(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.inval = inval_stim | inval_mem;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [3:0] ref_entry(input logic [3:0] e, input logic [2:0] acc);
    if (e[3] == 1'b0) return 4'd4;
    for (int i = 0; i < 3; i++)
      if (acc[i] && !e[i]) return 4'd5;
    return 4'd0;
  endfunction

  task automatic pulse_inval();
    @(posedge clk); #1 inval_stim = 1'b1;
    @(posedge clk); #1 inval_stim = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((exp_q.size() != 0 || cur_active) && k < 3000);
    chk("drain_pending", 64'(exp_q.size()), 0);
  endtask

  task automatic do_req(input logic [47:0] adr, input logic [2:0] acc, input logic [3:0] num,
                        input logic [19:0] at, input logic [47:0] pmt, input logic rerr,
                        input int unsigned dly, input logic [31:0] dat, input logic merr,
                        input bit noack, input bit inval_mid, input bit abort);
    exp_t        e;
    plan_t       p;
    logic [13:0] page;
    logic [3:0]  cause;
    bit          fetch;
    bit          denied;
    int          k;
    page   = adr[29:16];
    fetch  = 1'b0;
    denied = 1'b0;
    for (int i = 0; i < 3; i++)
      if (acc[i] && !at[i]) denied = 1'b1;
    if (rerr)                                   cause = 4'd1;
    else if (denied)                            cause = 4'd2;
    else if (pmt == 48'd0)                      cause = 4'd0;
    else if (m_valid && m_tag == {num, page})   cause = ref_entry(m_entry, acc);
    else begin
      fetch       = 1'b1;
      p.adr       = pmt + (48'(page) << 2);
      p.dly       = dly;
      p.dat       = dat;
      p.err       = merr;
      p.noack     = noack;
      p.abort     = abort;
      p.inval_mid = inval_mid;
      mem_q.push_back(p);
      if (noack || merr) cause = 4'd3;
      else               cause = ref_entry(dat[3:0], acc);
      if (inval_mid) m_valid = 1'b0;
      else if (!noack && !merr) begin
        m_valid = 1'b1;
        m_tag   = {num, page};
        m_entry = dat[3:0];
      end
    end
    e.ok      = (cause == 4'd0);
    e.cause   = cause;
    e.cac     = e.ok & at[3];
    e.chk_lat = !fetch;

    @(posedge clk); #1;
    bus.req_adr    = adr;
    bus.req_acc    = acc;
    bus.region_num = num;
    bus.region_at  = at;
    bus.region_pmt = pmt;
    bus.region_err = rerr;
    bus.req_valid  = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("req_accept", 64'(bus.req_ready), 1);
    e.acc_cyc = cyc;
    if (!abort) exp_q.push_back(e);
    @(posedge clk); #1;
    // Scramble the request side to show the accepted values were captured.
    bus.req_valid  = 1'b0;
    bus.req_adr    = {$urandom, $urandom};
    bus.req_acc    = 3'($urandom);
    bus.region_num = 4'($urandom);
    bus.region_at  = 20'($urandom);
    bus.region_pmt = {$urandom, $urandom};
    bus.region_err = 1'($urandom);
    if (!abort) wait_idle();
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    exp_t cur;
    bit   first;
    bus.rsp_ready = 1'b0;
    cur_active    = 1'b0;
    first         = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.rsp_ready = 1'b0;
        cur_active    = 1'b0;
        continue;
      end
      if (bus.rsp_valid) begin
        if (!cur_active) begin
          if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL rsp_unexpected: got rsp_valid=1, required 0 (cycle %0d)", cyc);
            bus.rsp_ready = 1'b1;
            continue;
          end
          cur        = exp_q.pop_front();
          cur_active = 1'b1;
          first      = 1'b1;
        end
        if (first && cur.chk_lat) chk("rsp_latency", 64'(cyc - cur.acc_cyc), 2);
        first = 1'b0;
        chk("rsp_ok", 64'(bus.rsp_ok), 64'(cur.ok));
        chk("rsp_cause", 64'(bus.rsp_cause), 64'(cur.cause));
        chk("rsp_cacheable", 64'(bus.rsp_cacheable), 64'(cur.cac));
        chk("req_ready_in_resp", 64'(bus.req_ready), 0);
        if (hold > 0) begin
          bus.rsp_ready = 1'b0;
          hold--;
        end else begin
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (bus.rsp_ready) cur_active = 1'b0;
      end else begin
        bus.rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // PMT memory: serves each read according to the plan queued by the stimulus.
  initial begin
    plan_t       p;
    int unsigned n;
    bus.mem_ack = 1'b0;
    bus.mem_dat = '0;
    bus.mem_err = 1'b0;
    inval_mem   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_req) begin
        if (mem_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_mem_req: got mem_req=1, required 0 (cycle %0d)", cyc);
          n = 0;
          while (bus.mem_req && rst_n && n < TMO + 20) begin
            n++;
            @(negedge clk);
          end
        end else begin
          p = mem_q.pop_front();
          chk("mem_adr", 64'(bus.mem_adr), 64'(p.adr));
          if (p.noack) begin
            n = 0;
            while (bus.mem_req && rst_n && n < TMO + 20) begin
              n++;
              @(negedge clk);
            end
            if (!p.abort) chk("tmo_cycles", 64'(n), 64'(TMO));
          end else begin
            if (p.inval_mid) begin
              @(posedge clk); #1 inval_mem = 1'b1;
              @(posedge clk); #1 inval_mem = 1'b0;
            end
            for (int unsigned i = 0; i < p.dly; i++) begin
              @(negedge clk);
              chk("mem_req_held", 64'(bus.mem_req), 1);
              chk("mem_adr_held", 64'(bus.mem_adr), 64'(p.adr));
            end
            @(posedge clk); #1;
            bus.mem_ack = 1'b1;
            bus.mem_dat = p.dat;
            bus.mem_err = p.err;
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            bus.mem_dat = $urandom;
            bus.mem_err = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed scenarios, then randomized traffic, then reset mid-fetch.
  initial begin
    int k;
    at_t[0]  = 20'h0000D; pmt_t[0] = 48'h0;
    at_t[1]  = 20'h0010F; pmt_t[1] = 48'h2400;
    at_t[2]  = 20'h00007; pmt_t[2] = 48'h1_0000_0000;
    at_t[3]  = 20'h0000F; pmt_t[3] = 48'hFFFF_FFFF_FFF8;
    page_t[0] = 14'h0000; page_t[1] = 14'h0001; page_t[2] = 14'h0002; page_t[3] = 14'h3FFF;
    n_assert = 0; n_fail = 0; hold = 0; m_valid = 1'b0;
    rst_n = 1'b0; inval_stim = 1'b0;
    bus.req_valid = 1'b0; bus.req_adr = '0; bus.req_acc = '0; bus.region_num = '0;
    bus.region_at = '0; bus.region_pmt = '0; bus.region_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("rst_mem_req", 64'(bus.mem_req), 0);
    chk("rst_mem_adr", 64'(bus.mem_adr), 0);
    chk("rst_rsp_ok", 64'(bus.rsp_ok), 0);
    chk("rst_rsp_cause", 64'(bus.rsp_cause), 0);
    chk("rst_rsp_cacheable", 64'(bus.rsp_cacheable), 0);
    rst_n = 1'b1;

    // ROM region without PMT.
    do_req(48'hFFFD0010, 3'b100, 4'd0, 20'h0000D, 48'h0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
    do_req(48'hFFFD0010, 3'b010, 4'd0, 20'h0000D, 48'h0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
    // DRAM region with PMT: miss and fetch, then hit.
    do_req(48'h00012340, 3'b100, 4'd1, 20'h0010F, 48'h2400, 1'b0, 3, 32'hF, 1'b0, 0, 0, 0);
    do_req(48'h00012340, 3'b100, 4'd1, 20'h0010F, 48'h2400, 1'b0, 3, 32'hF, 1'b0, 0, 0, 0);
    // Reloaded entry without W denies a write, both fetched and cached.
    pulse_inval();
    do_req(48'h00012340, 3'b010, 4'd1, 20'h0010F, 48'h2400, 1'b0, 2, 32'hD, 1'b0, 0, 0, 0);
    do_req(48'h00012340, 3'b010, 4'd1, 20'h0010F, 48'h2400, 1'b0, 2, 32'hD, 1'b0, 0, 0, 0);
    // Invalid entry, then a probe hitting it.
    pulse_inval();
    do_req(48'h00012340, 3'b100, 4'd1, 20'h0010F, 48'h2400, 1'b0, 1, 32'h7, 1'b0, 0, 0, 0);
    do_req(48'h00012340, 3'b000, 4'd1, 20'h0010F, 48'h2400, 1'b0, 1, 32'h7, 1'b0, 0, 0, 0);
    // Invalidate during the fetch: this response uses the entry, the next request refetches.
    pulse_inval();
    do_req(48'h00012340, 3'b100, 4'd1, 20'h0010F, 48'h2400, 1'b0, 2, 32'hF, 1'b0, 0, 1, 0);
    do_req(48'h00012340, 3'b100, 4'd1, 20'h0010F, 48'h2400, 1'b0, 0, 32'hF, 1'b0, 0, 0, 0);
    // No ack times out. A bus error is not cached.
    do_req(48'h00020000, 3'b100, 4'd1, 20'h0010F, 48'h2400, 1'b0, 0, 0, 1'b0, 1, 0, 0);
    do_req(48'h00030000, 3'b100, 4'd1, 20'h0010F, 48'h2400, 1'b0, 1, 32'hF, 1'b1, 0, 0, 0);
    do_req(48'h00030000, 3'b100, 4'd1, 20'h0010F, 48'h2400, 1'b0, 1, 32'hF, 1'b0, 0, 0, 0);
    // No region matched, with the response held for 5 cycles.
    hold = 5;
    do_req(48'h00012340, 3'b100, 4'd1, 20'h0010F, 48'h2400, 1'b1, 0, 0, 1'b0, 0, 0, 0);

    // Randomized traffic over a few regions and pages, including a wrapping PMT base.
    for (int n = 0; n < 120; n++) begin
      int unsigned r;
      int unsigned pg;
      logic [47:0] adr;
      r  = $urandom_range(0, 3);
      pg = $urandom_range(0, 3);
      adr = {2'($urandom), 16'($urandom), page_t[pg], 16'($urandom)};
      if ($urandom_range(0, 7) == 0) pulse_inval();
      if ($urandom_range(0, 5) == 0) hold = $urandom_range(1, 3);
      do_req(adr, 3'($urandom), 4'(r), at_t[r] | (20'($urandom) & 20'hFFFF0), pmt_t[r],
             1'($urandom_range(0, 9) == 0), $urandom_range(0, 4),
             {$urandom} & 32'hFFFF_FFFF, 1'($urandom_range(0, 11) == 0),
             0, ($urandom_range(0, 7) == 0), 0);
    end

    // Cache page 1 of region 1, then reset during a fetch of another page.
    pulse_inval();
    do_req(48'h00012340, 3'b100, 4'd1, 20'h0010F, 48'h2400, 1'b0, 0, 32'hF, 1'b0, 0, 0, 0);
    do_req(48'h00050000, 3'b100, 4'd1, 20'h0010F, 48'h2400, 1'b0, 0, 0, 1'b0, 1, 0, 1);
    k = 0;
    @(negedge clk);
    while (!bus.mem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("fetch_started", 64'(bus.mem_req), 1);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_fetch_mem_req", 64'(bus.mem_req), 0);
    chk("rst_mid_fetch_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("rst_mid_fetch_req_ready", 64'(bus.req_ready), 1);
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // The page cached before reset must be fetched again.
    do_req(48'h00012340, 3'b100, 4'd1, 20'h0010F, 48'h2400, 1'b0, 1, 32'hF, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("mem_plans_consumed", 64'(mem_q.size()), 0);
    chk("responses_consumed", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rfphoenix_pma_checker.md
Name: rfphoenix_pma_checker

Overview:
Downstream consumer of the active-region lookup. It takes a physical-address request plus the matched region descriptor (number, attributes, PMT base, error) and checks the requested access against the region attributes. If the region has a physical memory table (PMT), it fetches the per-page PMT entry over a simple memory handshake, caching one entry, and returns a grant or fault with a cause code to the load/store and fetch front-end.

Parameters:
PAGE_SHIFT, 16, log2 of PMT page size in bytes; page index = adr[PAGE_SHIFT+13:PAGE_SHIFT] (14 bits).
TMO, 255, cycles to wait for mem_ack before faulting; counter width $clog2(TMO+1).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_adr  in  48  physical address
req_acc  in  3  access kind: [0] execute, [1] write, [2] read
region_num  in  4  matched region number
region_at  in  20  region attributes: [0] X, [1] W, [2] R, [3] cacheable
region_pmt  in  48  PMT base address; 0 = no PMT for region
region_err  in  1  no region matched
inval  in  1  drop cached PMT entry (pulsed after region/PMT writes)
mem_req  out  1  PMT word read request
mem_adr  out  48  PMT word address
mem_ack  in  1  read complete, mem_dat valid
mem_dat  in  32  PMT entry: [2:0] X/W/R allow (same order as req_acc), [3] valid
mem_err  in  1  bus error, qualified by mem_ack
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_ok  out  1  access granted
rsp_cause  out  4  0 ok, 1 no region, 2 region deny, 3 PMT bus error/timeout, 4 PMT entry invalid, 5 PMT deny
rsp_cacheable  out  1  region_at[3] & rsp_ok

Behaviour:
- Reset: state IDLE; req_ready=1 and rsp_valid=0; mem_req=0, mem_adr=0; rsp_ok=0, rsp_cause=0, rsp_cacheable=0; cache valid=0; timeout counter=0. Reset during FETCH drops mem_req immediately. Any late mem_ack is ignored.
- On acceptance, req_adr, req_acc and all region_* inputs are latched; later changes to them have no effect.
- FSM: IDLE -> CHECK -> (FETCH) -> RESP -> IDLE. req_ready = (state==IDLE).
- CHECK, one cycle. Apply the first rule that matches, in this priority:
  - region_err -> cause 1.
  - (req_acc & ~region_at[2:0]) != 0 -> cause 2.
  - region_pmt==0 -> ok.
  - Cache hit (valid, tag {region_num, page} matches) -> evaluate cached entry.
  - Otherwise go to FETCH.
- Latency: with no fetch, rsp_valid rises 2 cycles after acceptance (accept at N, CHECK at N+1, rsp_valid at N+2).
- FETCH: mem_req=1 and mem_adr = region_pmt + (page<<2), held stable until mem_ack. The cycle after mem_ack, mem_req=0 and the state is RESP.
  - mem_err -> cause 3; cache not written.
  - Otherwise the entry is evaluated and written to the cache with its tag.
- TMO: if TMO cycles elapse in FETCH with no ack, mem_req drops and cause 3; the cache is not written.
- Entry evaluation, first match applies: entry[3]==0 -> cause 4; (req_acc & ~entry[2:0]) != 0 -> cause 5; otherwise ok.
- req_acc==0 is a probe: ok when the region matches, but still performs PMT valid check (cause 4 possible).
- RESP: rsp_* outputs stay stable until rsp_ready. On the handshake cycle the state returns to IDLE. Back-to-back throughput: one request per 3 cycles minimum.
- inval clears cache valid the same edge. If inval arrives during FETCH, the returning entry is used for the in-flight response but not cached. If inval and a cache write fall in the same cycle, inval wins.
- Arithmetic: mem_adr sum is 48-bit modulo 2^48, and carry is discarded.

Test Plan:
- ROM region (at=0x0000D, pmt=0) with adr 0xFFFD0010: acc=R -> rsp_ok=1, cacheable=1, rsp_valid 2 cycles after accept, no mem_req. acc=W -> rsp_ok=0, cause 2.
- DRAM region 1 (at=0x0010F, pmt=0x2400) with adr 0x00012340, acc=R: mem_adr=0x2404; ack after 3 cycles with mem_dat=0xF -> ok, cacheable=1. Repeat to the same page -> no mem_req, response at N+2.
- After the above, write to the same page with cached entry 0x0000000D (no W): first reload via mem_dat=0xD after inval -> cause 5. mem_dat=0x7 (valid=0) -> cause 4.
- inval pulsed mid-FETCH: response uses the fetched entry. Next same-page request issues mem_req again.
- No mem_ack with TMO=255: mem_req drops after 255 cycles -> cause 3. Separately, mem_ack with mem_err=1 -> cause 3 and not cached.
- region_err=1 -> cause 1. Hold rsp_ready=0 for 5 cycles: outputs stable and req_ready=0. Assert rst_n=0 mid-FETCH: mem_req=0 and rsp_valid=0 immediately.
